zedcomp_pipe: RTL and testbench
===============================

Name: zedcomp_pipe

Overview:
- Parametrised, pipelined successor to the blitter's 4-lane Z comparator.
- Compares LANES source Z values against destination Z values per phrase and produces a per-lane write-inhibit mask, selected by zmode.
- Adds configurable Z width, optional signed compare, per-lane enable, valid/ready flow control, and a saturating inhibit statistics counter.
- Sits between the blitter Z-source/Z-destination datapath and the data write-enable logic.

Parameters:
- LANES, 4, number of Z lanes per phrase (1..8).
- ZW, 16, Z value width in bits (8..32).
- CNTW, 16, width of the inhibited-lane statistics counter.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- resetl  in  1  asynchronous active-low reset.
- in_valid  in  1  phrase operands valid.
- in_ready  out  1  block accepts operands this cycle.
- srcz  in  LANES*ZW  source Z; lane i at [i*ZW +: ZW].
- dstz  in  LANES*ZW  destination Z; same packing.
- lane_en  in  LANES  lane participates; a disabled lane is never inhibited.
- zmode  in  3  bit0 inhibit if src<dst; bit1 inhibit if src==dst; bit2 inhibit if src>dst.
- zsigned  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream consumes result.
- zinhibit  out  LANES  per-lane inhibit mask.
- zall  out  1  every enabled lane inhibited; 0 if lane_en was all-zero.
- zcnt  out  CNTW  saturating count of inhibited lanes over consumed results.
- cnt_clr  in  1  synchronous clear of zcnt.

Behaviour:
- Reset (resetl low, asynchronous): s1_valid=0, out_valid=0, zinhibit=0, zall=0, zcnt=0.
- Pipeline has two registered stages.
  - S1: per-lane lt/eq flags, plus snapshots of zmode and lane_en.
  - S2: output register holding zinhibit and zall.
  - Inputs are sampled only when in_valid && in_ready.
- Per-lane compare:
  - Compare is lt/eq only; gt = !lt && !eq.
  - Signed compare uses the MSB of each ZW field as the sign.
  - Width rule: no lane sees bits of another lane.
- Output mapping:
  - inhibit[i] = lane_en[i] & ((zmode[0]&lt) | (zmode[1]&eq) | (zmode[2]&gt)).
  - zmode=000: never inhibit. zmode=111: inhibit every enabled lane.
- Latency and throughput: with no stall, an accepted phrase appears on out_valid 2 cycles after acceptance. Full throughput, one phrase per cycle.
- Flow control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Stall: while out_valid && !out_ready, zinhibit and zall are held stable and S1 holds its contents. No data is lost or duplicated.
- Drain: out_valid falls in the cycle after the last result is consumed, provided S1 is empty.
- Counter:
  - On out_valid && out_ready, zcnt += popcount(zinhibit), saturating at 2^CNTW-1. No wrap.
  - If cnt_clr is asserted, zcnt becomes 0 and the same-cycle increment is discarded.
- Operands change while in_ready=0: ignored.
- Reset mid-stream discards both stages immediately.

Decomposition:
- Shared package zed_pkg:
  - zmode bit indices ZM_LT=0, ZM_EQ=1, ZM_GT=2.
  - Typedef zmode_t (3 bits).
  - Function popcount over LANES.
- Sub-module zedcomp_lane (parameter ZW): combinational lt/eq for one lane with the zsigned input; instantiated LANES times via generate.
- Pipeline registers, handshake and counter live in zedcomp_pipe.

Test Plan:
- Unsigned, LANES=4, ZW=16, zmode=001, src={0010,0020,0030,0040}h, dst=0020h all lanes, lane_en=1111 -> zinhibit=0001 two cycles later; zall=0; zcnt=1 after consume.
- zsigned=1, zmode=001, src lane0=FFFFh, dst lane0=0001h -> inhibit[0]=1. Same operands with zsigned=0 -> inhibit[0]=0.
- zmode=111, lane_en=0101 -> zinhibit=0101, zall=1. lane_en=0000 -> zinhibit=0000, zall=0.
- Back-to-back 3 phrases with out_ready low for 4 cycles after the first result -> in_ready drops once both stages are full; zinhibit is held constant; all 3 results are delivered in order once out_ready rises.
- CNTW=4, 5 consumed phrases at 4 inhibits each -> zcnt saturates at 15. cnt_clr in the same cycle as a handshake -> zcnt=0.
- Assert resetl low with both stages full -> out_valid=0, zcnt=0 asynchronously; first post-reset phrase emerges after 2 cycles.

Source files
------------

// File: rtl/zed_pkg.sv
// Shared definitions for the pipelined Z comparator: zmode bit positions,
// the zmode type and a lane popcount helper sized for the widest phrase.
package zed_pkg;

   localparam int unsigned ZM_LT     = 0;
   localparam int unsigned ZM_EQ     = 1;
   localparam int unsigned ZM_GT     = 2;
   localparam int unsigned MAX_LANES = 8;

   typedef logic [2:0] zmode_t;

   // Number of set bits in a lane mask; narrower masks are zero-extended by the caller.
   function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/zedcomp_lane.sv
// One Z lane: combinational less-than / equal flags, signed or unsigned.
// Greater-than is derived downstream from these two flags.
module zedcomp_lane #(
   parameter int unsigned ZW = 16
) (
   input  logic [ZW-1:0] src_i,
   input  logic [ZW-1:0] dst_i,
   input  logic          zsigned_i,
   output logic          lt_o,
   output logic          eq_o
);

   // Equality is sign-agnostic; only the ordering depends on zsigned_i.
   always_comb begin
      eq_o = (src_i == dst_i);
      if (zsigned_i) begin
         lt_o = ($signed(src_i) < $signed(dst_i));
      end else begin
         lt_o = (src_i < dst_i);
      end
   end

endmodule

// File: rtl/zedcomp_pipe.sv
// Two-stage pipelined Z comparator producing a per-lane write-inhibit mask.
// S1 registers lt/eq flags with the zmode and lane_en snapshot; S2 holds the
// mask and zall. Valid/ready backpressure has no skid buffer, so in_ready is
// combinational from out_ready. A saturating counter totals inhibited lanes.
module zedcomp_pipe
   import zed_pkg::*;
#(
   parameter int unsigned LANES = 4,
   parameter int unsigned ZW    = 16,
   parameter int unsigned CNTW  = 16
) (
   input  logic                sys_clk,
   input  logic                resetl,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LANES*ZW-1:0] srcz,
   input  logic [LANES*ZW-1:0] dstz,
   input  logic [LANES-1:0]    lane_en,
   input  logic [2:0]          zmode,
   input  logic                zsigned,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LANES-1:0]    zinhibit,
   output logic                zall,
   output logic [CNTW-1:0]     zcnt,
   input  logic                cnt_clr
);

   // Sum is wide enough for counter max plus a full phrase of inhibits.
   localparam int unsigned    SUMW    = CNTW + 4;
   localparam logic [SUMW-1:0] CNT_MAX = {4'b0000, {CNTW{1'b1}}};

   logic [LANES-1:0] lane_lt;
   logic [LANES-1:0] lane_eq;

   logic             s1_valid_q, s1_valid_d;
   logic [LANES-1:0] s1_lt_q, s1_lt_d;
   logic [LANES-1:0] s1_eq_q, s1_eq_d;
   logic [LANES-1:0] s1_en_q, s1_en_d;
   zmode_t           s1_zmode_q, s1_zmode_d;

   logic             out_valid_q, out_valid_d;
   logic [LANES-1:0] zinhibit_q, zinhibit_d;
   logic             zall_q, zall_d;
   logic [CNTW-1:0]  zcnt_q, zcnt_d;

   logic             s1_adv;
   logic             s2_adv;
   logic [LANES-1:0] s1_inh;
   logic             s1_all;
   logic [MAX_LANES-1:0] inh_ext;
   logic [SUMW-1:0]  cnt_sum;

   // Per-lane comparators see only their own ZW-bit slice.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      zedcomp_lane #(
         .ZW(ZW)
      ) u_lane (
         .src_i    (srcz[i*ZW +: ZW]),
         .dst_i    (dstz[i*ZW +: ZW]),
         .zsigned_i(zsigned),
         .lt_o     (lane_lt[i]),
         .eq_o     (lane_eq[i])
      );
   end

   // Handshake: a stage advances when the stage after it can take its contents.
   always_comb begin
      s2_adv   = ~out_valid_q | out_ready;
      s1_adv   = ~s1_valid_q | s2_adv;
      in_ready = s1_adv;
   end

   // Map S1 flags through the captured zmode; disabled lanes never inhibit.
   always_comb begin
      s1_inh = '0;
      for (int i = 0; i < LANES; i++) begin
         s1_inh[i] = s1_en_q[i] &
                     ((s1_zmode_q[ZM_LT] & s1_lt_q[i]) |
                      (s1_zmode_q[ZM_EQ] & s1_eq_q[i]) |
                      (s1_zmode_q[ZM_GT] & ~s1_lt_q[i] & ~s1_eq_q[i]));
      end
      s1_all = (|s1_en_q) & (s1_inh == s1_en_q);
   end

   // Pipeline next state: stages load only when advancing, otherwise hold.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_lt_d     = s1_lt_q;
      s1_eq_d     = s1_eq_q;
      s1_en_d     = s1_en_q;
      s1_zmode_d  = s1_zmode_q;
      out_valid_d = out_valid_q;
      zinhibit_d  = zinhibit_q;
      zall_d      = zall_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_lt_d    = lane_lt;
            s1_eq_d    = lane_eq;
            s1_en_d    = lane_en;
            s1_zmode_d = zmode;
         end
      end
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            zinhibit_d = s1_inh;
            zall_d     = s1_all;
         end
      end
   end

   // Statistics counter: add inhibited lanes per consumed result, clamp, clear wins.
   always_comb begin
      inh_ext              = '0;
      inh_ext[LANES-1:0]   = zinhibit_q;
      cnt_sum              = {4'b0000, zcnt_q} + SUMW'(popcount(inh_ext));
      zcnt_d               = zcnt_q;
      if (cnt_clr) begin
         zcnt_d = '0;
      end else if (out_valid_q && out_ready) begin
         zcnt_d = (cnt_sum > CNT_MAX) ? {CNTW{1'b1}} : cnt_sum[CNTW-1:0];
      end
   end

   // State registers; reset empties both stages and clears the counter at once.
   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         s1_valid_q  <= 1'b0;
         s1_lt_q     <= '0;
         s1_eq_q     <= '0;
         s1_en_q     <= '0;
         s1_zmode_q  <= '0;
         out_valid_q <= 1'b0;
         zinhibit_q  <= '0;
         zall_q      <= 1'b0;
         zcnt_q      <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_lt_q     <= s1_lt_d;
         s1_eq_q     <= s1_eq_d;
         s1_en_q     <= s1_en_d;
         s1_zmode_q  <= s1_zmode_d;
         out_valid_q <= out_valid_d;
         zinhibit_q  <= zinhibit_d;
         zall_q      <= zall_d;
         zcnt_q      <= zcnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign zinhibit  = zinhibit_q;
   assign zall      = zall_q;
   assign zcnt      = zcnt_q;

endmodule

// File: tb/tb_zedcomp_pipe.sv
// Bench for zedcomp_pipe: directed scenarios plus random traffic, checked
// against a queue-based reference model of accepted phrases.
`timescale 1ns/1ps
module tb_zedcomp_pipe;

   localparam int LANES = 4;
   localparam int ZW    = 16;

   logic                sys_clk = 1'b0;
   logic                resetl  = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready, in_ready4;
   logic [LANES*ZW-1:0] srcz = '0;
   logic [LANES*ZW-1:0] dstz = '0;
   logic [LANES-1:0]    lane_en = '0;
   logic [2:0]          zmode = '0;
   logic                zsigned = 1'b0;
   logic                out_valid, out_valid4;
   logic                out_ready = 1'b0;
   logic [LANES-1:0]    zinhibit, zinhibit4;
   logic                zall, zall4;
   logic [15:0]         zcnt;
   logic [3:0]          zcnt4;
   logic                cnt_clr = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [3:0]  q_inh[$];
   bit          q_all[$];
   longint      q_acc[$];
   longint      ecnt  = 0;
   int unsigned mcnt  = 0;
   int unsigned mcnt4 = 0;

   always #5 sys_clk = ~sys_clk;

   zedcomp_pipe #(.LANES(LANES), .ZW(ZW), .CNTW(16)) dut (
      .sys_clk(sys_clk), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready),
      .srcz(srcz), .dstz(dstz), .lane_en(lane_en), .zmode(zmode), .zsigned(zsigned),
      .out_valid(out_valid), .out_ready(out_ready), .zinhibit(zinhibit), .zall(zall),
      .zcnt(zcnt), .cnt_clr(cnt_clr)
   );

   zedcomp_pipe #(.LANES(LANES), .ZW(ZW), .CNTW(4)) dut4 (
      .sys_clk(sys_clk), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready4),
      .srcz(srcz), .dstz(dstz), .lane_en(lane_en), .zmode(zmode), .zsigned(zsigned),
      .out_valid(out_valid4), .out_ready(out_ready), .zinhibit(zinhibit4), .zall(zall4),
      .zcnt(zcnt4), .cnt_clr(cnt_clr)
   );

   function automatic bit model_ov();
      return (q_inh.size() > 0) && (ecnt - q_acc[0] >= 1);
   endfunction

   // Input blocked only when two phrases are in flight and the output is stalled.
   function automatic bit model_inr();
      return !(model_ov() && !out_ready && q_inh.size() >= 2);
   endfunction

   task automatic model_clear();
      q_inh.delete(); q_all.delete(); q_acc.delete();
      mcnt = 0; mcnt4 = 0;
   endtask

   task automatic ref_phrase(output logic [3:0] inh, output bit all);
      longint a, b;
      logic [ZW-1:0] s, d;
      bit c;
      inh = '0;
      for (int i = 0; i < LANES; i++) begin
         s = srcz[i*ZW +: ZW];
         d = dstz[i*ZW +: ZW];
         a = longint'(s);
         b = longint'(d);
         if (zsigned && s[ZW-1]) a = a - (longint'(1) << ZW);
         if (zsigned && d[ZW-1]) b = b - (longint'(1) << ZW);
         c = (zmode[0] && a < b) || (zmode[1] && a == b) || (zmode[2] && a > b);
         inh[i] = lane_en[i] && c;
      end
      all = (lane_en != 0) && (inh == lane_en);
   endtask

   // One clock: advance the model alongside the DUT, end at the falling edge.
   task automatic tick();
      bit ov, inr, push, nall;
      logic [3:0] ninh;
      int pc;
      ov   = model_ov();
      inr  = model_inr();
      push = in_valid && inr;
      ninh = '0;
      nall = 0;
      if (push) ref_phrase(ninh, nall);
      @(posedge sys_clk);
      if (cnt_clr) begin
         mcnt = 0; mcnt4 = 0;
      end else if (ov && out_ready) begin
         pc    = $countones(q_inh[0]);
         mcnt  = (mcnt + pc > 65535) ? 65535 : mcnt + pc;
         mcnt4 = (mcnt4 + pc > 15) ? 15 : mcnt4 + pc;
      end
      if (ov && out_ready) begin
         void'(q_inh.pop_front()); void'(q_all.pop_front()); void'(q_acc.pop_front());
      end
      if (push) begin
         q_inh.push_back(ninh); q_all.push_back(nall); q_acc.push_back(ecnt + 1);
      end
      ecnt++;
      @(negedge sys_clk);
   endtask

   task automatic rand_ops();
      logic [ZW-1:0] s, d;
      for (int i = 0; i < LANES; i++) begin
         s = ZW'($urandom);
         case ($urandom_range(0, 3))
            0:       d = s;
            1:       d = s + 1'b1;
            2:       d = s - 1'b1;
            default: d = ZW'($urandom);
         endcase
         srcz[i*ZW +: ZW] = s;
         dstz[i*ZW +: ZW] = d;
      end
   endtask

   task automatic set_phrase(input logic [63:0] s, input logic [63:0] d, input logic [3:0] en,
                             input logic [2:0] zm, input logic sg);
      in_valid = 1'b1; srcz = s; dstz = d; lane_en = en; zmode = zm; zsigned = sg;
   endtask

   task automatic do_reset();
      resetl = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      model_clear();
      @(negedge sys_clk);
      @(negedge sys_clk);
      resetl = 1'b1;
   endtask

   task automatic test_reset();
      #1 resetl = 1'b0;
      model_clear();
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if (zinhibit !== 4'b0000) begin miscompares++; $display("FAIL reset_zinhibit got %b want 0000", zinhibit); end
      vectors++; if (zall !== 1'b0) begin miscompares++; $display("FAIL reset_zall got %b want 0", zall); end
      vectors++; if (zcnt !== 16'd0) begin miscompares++; $display("FAIL reset_zcnt got %0d want 0", zcnt); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(negedge sys_clk);
      @(negedge sys_clk);
      resetl = 1'b1;
   endtask

   task automatic test_unsigned();
      set_phrase({16'h0040, 16'h0030, 16'h0020, 16'h0010}, {4{16'h0020}}, 4'b1111, 3'b001, 1'b0);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL uns_latency1 got %b want 0", out_valid); end
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL uns_latency2 got %b want 1", out_valid); end
      vectors++; if (zinhibit !== 4'b0001) begin miscompares++; $display("FAIL uns_zinhibit got %b want 0001", zinhibit); end
      vectors++; if (zall !== 1'b0) begin miscompares++; $display("FAIL uns_zall got %b want 0", zall); end
      tick();
      vectors++; if (zcnt !== 16'd1) begin miscompares++; $display("FAIL uns_zcnt got %0d want 1", zcnt); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL uns_drain got %b want 0", out_valid); end
   endtask

   task automatic test_signed();
      set_phrase(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 4'b1111, 3'b001, 1'b1);
      out_ready = 1'b1;
      tick();
      zsigned = 1'b0;
      tick();
      in_valid = 1'b0;
      vectors++; if (zinhibit !== 4'b0001) begin miscompares++; $display("FAIL signed_lt got %b want 0001", zinhibit); end
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL unsigned_valid got %b want 1", out_valid); end
      vectors++; if (zinhibit !== 4'b0000) begin miscompares++; $display("FAIL unsigned_gt got %b want 0000", zinhibit); end
      tick();
   endtask

   task automatic test_lane_en();
      rand_ops();
      set_phrase(srcz, dstz, 4'b0101, 3'b111, 1'b0);
      out_ready = 1'b1;
      tick();
      lane_en = 4'b0000;
      tick();
      in_valid = 1'b0;
      vectors++; if (zinhibit !== 4'b0101) begin miscompares++; $display("FAIL en_mask got %b want 0101", zinhibit); end
      vectors++; if (zall !== 1'b1) begin miscompares++; $display("FAIL en_zall got %b want 1", zall); end
      tick();
      vectors++; if (zinhibit !== 4'b0000) begin miscompares++; $display("FAIL en_none got %b want 0000", zinhibit); end
      vectors++; if (zall !== 1'b0) begin miscompares++; $display("FAIL en_none_zall got %b want 0", zall); end
      tick();
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int got_dut = 0;
      int low_dut = 0;
      bit ov;
      for (int c = 0; c < 14; c++) begin
         out_ready = !(c >= 2 && c < 6);
         if (sent < 3) begin
            if (!in_valid) begin rand_ops(); zmode = 3'($urandom); lane_en = 4'($urandom); end
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         ov = model_ov();
         vectors++; if (out_valid !== ov) begin miscompares++; $display("FAIL b2b_valid c=%0d got %b want %b", c, out_valid, ov); end
         vectors++; if (in_ready !== model_inr()) begin miscompares++; $display("FAIL b2b_in_ready c=%0d got %b want %b", c, in_ready, model_inr()); end
         if (ov) begin
            vectors++; if (zinhibit !== q_inh[0]) begin miscompares++; $display("FAIL b2b_zinhibit c=%0d got %b want %b", c, zinhibit, q_inh[0]); end
         end
         if (out_valid && out_ready) got_dut++;
         if (!in_ready) low_dut++;
         if (in_valid && model_inr()) begin
            sent++;
            tick();
            in_valid = (sent < 3) ? 1'b0 : in_valid;
         end else begin
            tick();
         end
      end
      in_valid = 1'b0;
      vectors++; if (got_dut !== 3) begin miscompares++; $display("FAIL b2b_delivered got %0d want 3", got_dut); end
      vectors++; if (low_dut !== 4) begin miscompares++; $display("FAIL b2b_ready_low got %0d want 4", low_dut); end
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_ops();
         set_phrase(srcz, dstz, 4'b1111, 3'b111, 1'($urandom));
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      vectors++; if (zcnt4 !== 4'd15) begin miscompares++; $display("FAIL sat_zcnt4 got %0d want 15", zcnt4); end
      vectors++; if (zcnt !== 16'd20) begin miscompares++; $display("FAIL sat_zcnt got %0d want 20", zcnt); end
      set_phrase(srcz, dstz, 4'b1111, 3'b111, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      vectors++; if (zcnt !== 16'd0) begin miscompares++; $display("FAIL clr_zcnt got %0d want 0", zcnt); end
      vectors++; if (zcnt4 !== 4'd0) begin miscompares++; $display("FAIL clr_zcnt4 got %0d want 0", zcnt4); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      out_ready = 1'b1;
      rand_ops();
      set_phrase(srcz, dstz, 4'b1111, 3'b111, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      vectors++; if (zcnt !== 16'd4) begin miscompares++; $display("FAIL mid_pre_zcnt got %0d want 4", zcnt); end
      out_ready = 1'b0;
      in_valid  = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_full got %b want 0", in_ready); end
      resetl = 1'b0;
      model_clear();
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
      vectors++; if (zcnt !== 16'd0) begin miscompares++; $display("FAIL mid_rst_zcnt got %0d want 0", zcnt); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got %b want 1", in_ready); end
      vectors++; if (zinhibit !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_zinhibit got %b want 0000", zinhibit); end
      @(negedge sys_clk);
      resetl    = 1'b1;
      out_ready = 1'b1;
      set_phrase(srcz, dstz, 4'b0011, 3'b111, 1'b0);
      tick();
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_early got %b want 0", out_valid); end
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL post_rst_valid got %b want 1", out_valid); end
      vectors++; if (zinhibit !== 4'b0011) begin miscompares++; $display("FAIL post_rst_zinhibit got %b want 0011", zinhibit); end
      vectors++; if (zall !== 1'b1) begin miscompares++; $display("FAIL post_rst_zall got %b want 1", zall); end
      tick();
   endtask

   task automatic test_random();
      bit ov;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cnt_clr   = ($urandom_range(0, 31) == 0);
         zmode     = 3'($urandom);
         lane_en   = 4'($urandom);
         zsigned   = 1'($urandom);
         rand_ops();
         #1;
         ov = model_ov();
         vectors++; if (out_valid !== ov) begin miscompares++; $display("FAIL rnd_valid c=%0d got %b want %b", c, out_valid, ov); end
         vectors++; if (in_ready !== model_inr()) begin miscompares++; $display("FAIL rnd_in_ready c=%0d got %b want %b", c, in_ready, model_inr()); end
         if (ov) begin
            vectors++; if (zinhibit !== q_inh[0]) begin miscompares++; $display("FAIL rnd_zinhibit c=%0d got %b want %b", c, zinhibit, q_inh[0]); end
            vectors++; if (zall !== q_all[0]) begin miscompares++; $display("FAIL rnd_zall c=%0d got %b want %b", c, zall, q_all[0]); end
            vectors++; if (zinhibit4 !== q_inh[0]) begin miscompares++; $display("FAIL rnd_zinhibit4 c=%0d got %b want %b", c, zinhibit4, q_inh[0]); end
         end
         vectors++; if (zcnt !== 16'(mcnt)) begin miscompares++; $display("FAIL rnd_zcnt c=%0d got %0d want %0d", c, zcnt, mcnt); end
         vectors++; if (zcnt4 !== 4'(mcnt4)) begin miscompares++; $display("FAIL rnd_zcnt4 c=%0d got %0d want %0d", c, zcnt4, mcnt4); end
         tick();
      end
      in_valid = 1'b0;
      cnt_clr  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_lane_en();
      test_back_to_back();
      test_saturation();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
